// File: rtl/msk_and_hpc3_stream_pkg.sv
`default_nettype none
// ============================================================================
// Package : msk_hpc3_pkg
// Index and sizing helpers shared by the masked HPC3 AND stream and its lanes.
// Rev     : 1.0
// ============================================================================
package msk_hpc3_pkg;

  // Fresh random bits needed per masked bit.
  function automatic int hpc3rnd(input int nshares);
    return nshares * (nshares - 1);
  endfunction

  // Triangular index of the unordered share pair {i, j}, i != j.
  function automatic int pair_idx(input int i, input int j, input int nshares);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * nshares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Flat vector position of share i of bit k.
  function automatic int share_idx(input int i, input int k, input int width);
    return i * width + k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msk_and_hpc3_stream_lane.sv
`default_nettype none
// ============================================================================
// Module : msk_hpc3_lane
// One masked bit of the HPC3 AND: stage-1 registers and share recombination.
// Rev    : 1.0
// ============================================================================
module msk_hpc3_lane
  import msk_hpc3_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [d-1:0]          a,
  input  logic [d-1:0]          b,
  input  logic [hpc3rnd(d)-1:0] rnd,
  output logic [d-1:0]          out
);

  localparam int c_np = d - 1;
  localparam int c_nr = hpc3rnd(d) / 2;

  logic [d*c_np-1:0] w_u;
  logic [d*c_np-1:0] w_v;
  logic [d*c_np-1:0] r_u;
  logic [d*c_np-1:0] r_v;
  logic [d-1:0]      r_a_prev;

  // u/v are packed per share i as its d-1 partners j, skipping j == i.
  for (genvar i = 0; i < d; i++) begin : g_share
    for (genvar j2 = 0; j2 < c_np; j2++) begin : g_pair
      localparam int c_j   = (j2 < i) ? j2 : j2 + 1;
      localparam int c_idx = pair_idx(i, c_j, d);
      logic w_r0;
      logic w_r1;
      assign w_r0 = rnd[c_idx];
      assign w_r1 = rnd[c_nr + c_idx];
      if (j2 == 0) begin : g_first
        assign w_u[i*c_np+j2] = (a[i] & (w_r0 ^ b[i])) ^ w_r1;
      end else begin : g_rest
        assign w_u[i*c_np+j2] = (a[i] & w_r0) ^ w_r1;
      end
      assign w_v[i*c_np+j2] = b[c_j] ^ w_r0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u      <= '0;
      r_v      <= '0;
      r_a_prev <= '0;
    end else if (en) begin
      r_u      <= w_u;
      r_v      <= w_v;
      r_a_prev <= a;
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < d; i++) begin
      out[i] = (^r_u[i*c_np +: c_np]) ^ (r_a_prev[i] & (^r_v[i*c_np +: c_np]));
    end
  end

endmodule
`default_nettype wire

// File: rtl/msk_and_hpc3_stream.sv
`default_nettype none
// ============================================================================
// Module : msk_and_hpc3_stream
// Streaming W-bit masked AND (HPC3 gadget) with valid/ready handshakes.
// Rev    : 1.0
// ============================================================================
module msk_and_hpc3_stream
  import msk_hpc3_pkg::*;
#(
  parameter  int d      = 2,
  parameter  int W      = 8,
  parameter  int OUTREG = 1,
  localparam int R      = W * hpc3rnd(d)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*d-1:0] ina,
  input  logic [W*d-1:0] inb,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  input  logic [R-1:0]   rnd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*d-1:0] out,
  output logic [15:0]    starve_cnt
);

  localparam int c_rpb = hpc3rnd(d);

  logic           r_s1_valid;
  logic           w_s1_adv;
  logic           w_load_ok;
  logic           w_fire;
  logic [W*d-1:0] w_s1_out;
  logic [15:0]    r_starve_cnt;

  assign w_load_ok = !r_s1_valid || w_s1_adv;
  assign w_fire    = in_valid && rnd_valid && w_load_ok;
  assign in_ready  = rst_n && rnd_valid && w_load_ok;
  assign rnd_ready = rst_n && in_valid && w_load_ok;

  // Lanes only load on a fire, so a stalled operation never re-masks with the same word.
  for (genvar k = 0; k < W; k++) begin : g_lane
    logic [d-1:0] w_a;
    logic [d-1:0] w_b;
    logic [d-1:0] w_o;
    for (genvar i = 0; i < d; i++) begin : g_map
      assign w_a[i] = ina[share_idx(i, k, W)];
      assign w_b[i] = inb[share_idx(i, k, W)];
      assign w_s1_out[share_idx(i, k, W)] = w_o[i];
    end
    msk_hpc3_lane #(.d(d)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_fire),
      .a     (w_a),
      .b     (w_b),
      .rnd   (rnd[k*c_rpb +: c_rpb]),
      .out   (w_o)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_load_ok) begin
      r_s1_valid <= w_fire;
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic           r_s2_valid;
    logic [W*d-1:0] r_out;

    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign out_valid = r_s2_valid;
    assign out       = r_out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_valid <= 1'b0;
        r_out      <= '0;
      end else if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out <= w_s1_out;
        end
      end
    end
  end else begin : g_direct
    assign w_s1_adv  = out_ready;
    assign out_valid = r_s1_valid;
    assign out       = w_s1_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (in_valid && !rnd_valid && (r_starve_cnt != 16'hFFFF)) begin
      r_starve_cnt <= r_starve_cnt + 16'd1;
    end
  end

  assign starve_cnt = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_msk_and_hpc3_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_msk_and_hpc3_stream
// Scoreboard bench for the masked HPC3 AND stream (d=3/W=8 registered, d=2/W=1 direct).
// Rev    : 1.0
// ============================================================================
module tb_msk_and_hpc3_stream;

  localparam int c_d = 3;
  localparam int c_w = 8;
  localparam int c_r = c_w * c_d * (c_d - 1);

  logic clk = 1'b0;
  logic rst_n;

  logic             in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
  logic [c_w*c_d-1:0] ina, inb, out;
  logic [c_r-1:0]   rnd;
  logic [15:0]      starve_cnt;

  logic       b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready, b_out_valid, b_out_ready;
  logic [1:0] b_ina, b_inb, b_rnd, b_out;
  logic [15:0] b_starve_cnt;

  always #5 clk = ~clk;

  msk_and_hpc3_stream #(.d(c_d), .W(c_w), .OUTREG(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .ina(ina), .inb(inb),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .starve_cnt(starve_cnt)
  );

  msk_and_hpc3_stream #(.d(2), .W(1), .OUTREG(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .ina(b_ina), .inb(b_inb),
    .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .rnd(b_rnd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .starve_cnt(b_starve_cnt)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t       vecs[8];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp;
  int         n_fire = 0, n_rnd = 0, n_out = 0, lowready_cnt = 0;
  bit         last_fire, last_out, last_in_ready, prev_hold;
  logic [23:0] prev_out;
  logic [15:0] m_starve;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] share3(input logic [7:0] v);
    logic [31:0] s0, s1;
    s0 = $urandom();
    s1 = $urandom();
    return {v ^ s0[7:0] ^ s1[7:0], s1[7:0], s0[7:0]};
  endfunction

  function automatic logic [7:0] unshare(input logic [23:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] y);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    ina = share3(a);
    inb = share3(b);
    rnd = t[c_r-1:0];
    in_valid = 1'b1;
    rnd_valid = 1'b1;
    cur_exp = y;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    last_out = out_valid && out_ready;
    if (last_out) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: got out_valid=1 required no pending result");
      end else begin
        check("out_value", 64'(unshare(out)), 64'(exp_q.pop_front()));
      end
    end
    if (prev_hold) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'(out), 64'(prev_out));
    end
    prev_hold = out_valid && !out_ready;
    prev_out = out;
    last_in_ready = in_ready;
    last_fire = in_valid && in_ready;
    if (last_fire) begin
      exp_q.push_back(cur_exp);
      n_fire++;
    end
    if (rnd_valid && rnd_ready) n_rnd++;
    if (rst_n && in_valid && !rnd_valid && m_starve != 16'hFFFF) m_starve++;
    @(negedge clk);
  endtask

  task automatic drain();
    int g;
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      step();
      g++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [31:0] t32;
    int g, lat, stall_left, fires_before;

    vecs[0] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[1] = '{8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'hAA, 8'h55, 8'h00};
    vecs[3] = '{8'hAA, 8'hFF, 8'hAA};
    vecs[4] = '{8'hF0, 8'h3C, 8'h30};
    vecs[5] = '{8'h81, 8'h81, 8'h81};
    vecs[6] = '{8'h0F, 8'hF3, 8'h03};
    vecs[7] = '{8'h5A, 8'hFE, 8'h5A};

    prev_hold = 1'b0;
    prev_out = '0;
    m_starve = '0;
    cur_exp = '0;
    ina = '0; inb = '0; rnd = '0;
    out_ready = 1'b1;
    b_ina = '0; b_inb = '0; b_rnd = '0;
    b_in_valid = 1'b0; b_rnd_valid = 1'b0; b_out_ready = 1'b1;

    // Reset state, with valids high to show the ready outputs are held off.
    rst_n = 1'b0;
    in_valid = 1'b1;
    rnd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_rnd_ready", 64'(rnd_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_starve", 64'(starve_cnt), 64'(0));
    check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Direct-output instance: one cycle latency and back-pressure on a full stage 1.
    b_ina = 2'b01; b_inb = 2'b10; b_rnd = 2'b10;
    b_in_valid = 1'b1; b_rnd_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    check("b_in_ready", 64'(b_in_ready), 64'(1));
    @(negedge clk);
    b_ina = 2'b10; b_inb = 2'b11; b_rnd = 2'b01;
    #1;
    check("b_latency", 64'(b_out_valid), 64'(1));
    check("b_and_1", 64'(b_out[0] ^ b_out[1]), 64'(1));
    @(negedge clk);
    b_ina = 2'b11; b_inb = 2'b01; b_out_ready = 1'b0;
    #1;
    check("b_valid_2", 64'(b_out_valid), 64'(1));
    check("b_and_0", 64'(b_out[0] ^ b_out[1]), 64'(0));
    check("b_backpressure", 64'(b_in_ready), 64'(0));
    @(negedge clk);
    b_in_valid = 1'b0; b_rnd_valid = 1'b0; b_out_ready = 1'b1;

    // Table vectors streamed back to back.
    for (int v = 0; v < 8; v++) begin
      drive_op(vecs[v].a, vecs[v].b, vecs[v].y);
      g = 0;
      do begin
        step();
        g++;
      end while (!last_fire && g < 10);
      check("vec_accept", 64'(last_fire), 64'(1));
    end
    drain();

    // Latency with no back-pressure: result two cycles after the fire.
    t32 = $urandom();
    drive_op(t32[7:0], t32[15:8], t32[7:0] & t32[15:8]);
    step();
    check("lat_fire", 64'(last_fire), 64'(1));
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!last_out && lat < 10);
    check("latency", 64'(lat), 64'(2));

    // Continuous random stream with a 5-cycle output stall mid-way.
    stall_left = 0;
    for (int n = 0; n < 1000; n++) begin
      t32 = $urandom();
      drive_op(t32[7:0], t32[15:8], t32[7:0] & t32[15:8]);
      if (n == 500) stall_left = 5;
      g = 0;
      do begin
        out_ready = (stall_left == 0);
        step();
        if (stall_left == 1) check("stall_backpressure", 64'(last_in_ready), 64'(0));
        if (stall_left > 0) stall_left--;
        else if (!last_in_ready) lowready_cnt++;
        g++;
      end while (!last_fire && g < 20);
      if (!last_fire) begin
        n_checks++;
        n_errors++;
        $display("FAIL stream_accept: got no fire for op %0d required accept within 20 cycles", n);
      end
    end
    drain();
    check("throughput_gaps", 64'(lowready_cnt), 64'(0));
    check("rnd_words_vs_ops", 64'(n_rnd), 64'(n_fire));
    check("results_vs_ops", 64'(n_out), 64'(n_fire));

    // Randomness starvation: no fire, counter saturates and holds.
    fires_before = n_fire;
    in_valid = 1'b1;
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("starve_100", 64'(starve_cnt), 64'(100));
    for (int i = 100; i < 70000; i++) step();
    check("starve_sat", 64'(starve_cnt), 64'(16'hFFFF));
    check("starve_model", 64'(starve_cnt), 64'(m_starve));
    check("starve_no_fire", 64'(n_fire), 64'(fires_before));
    check("starve_no_out", 64'(out_valid), 64'(0));

    // Asynchronous reset with two operations in flight.
    out_ready = 1'b0;
    t32 = $urandom();
    drive_op(t32[7:0], t32[15:8], t32[7:0] & t32[15:8]);
    step();
    drive_op(t32[23:16], t32[31:24], t32[23:16] & t32[31:24]);
    step();
    check("inflight_2", 64'(last_fire), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_starve", 64'(starve_cnt), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    m_starve = '0;
    prev_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive_op(vecs[4].a, vecs[4].b, vecs[4].y);
    step();
    check("first_fire_after_reset", 64'(last_fire), 64'(1));
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
